uart_rx: RTL and testbench

Asynchronous serial receiver for the UART interface: samples one serial line, recovers 8-bit frames (start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits) and presents each byte with a one-cycle valid strobe and error flags. It is the receive-side counterpart to the UART transmitter and uses the same divider and frame-format inputs, so a transmitter and a receiver driven by identical configuration interoperate.

---
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized serial input, mid-bit sampling, 8 data bits LSB first,
// optional parity and 1/2 stop bits; delivers each byte with a one-cycle valid strobe.
module uart_rx #(
  parameter int unsigned CLOCK_DIVIDER_WIDTH = 16
) (
  input  logic                           clock_i,
  input  logic                           reset_n_i,
  input  logic                           serial_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic                           two_stop_bits_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  output logic [7:0]                     data_o,
  output logic                           valid_o,
  output logic                           parity_error_o,
  output logic                           framing_error_o,
  output logic                           busy_o
);

  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_PARITY    = 3'd4;
  localparam logic [2:0] ST_STOP      = 3'd5;

  localparam logic [CLOCK_DIVIDER_WIDTH-1:0] DIV_ONE = CLOCK_DIVIDER_WIDTH'(1);
  localparam logic [CLOCK_DIVIDER_WIDTH-1:0] DIV_MIN = CLOCK_DIVIDER_WIDTH'(4);

  logic [1:0]                     sync_q, sync_d;
  logic                           rx_prev_q, rx_prev_d;
  logic [2:0]                     state_q, state_d;
  logic [CLOCK_DIVIDER_WIDTH-1:0] timer_q, timer_d;
  logic [CLOCK_DIVIDER_WIDTH-1:0] div_q, div_d;
  logic                           two_stop_q, two_stop_d;
  logic                           par_en_q, par_en_d;
  logic                           par_even_q, par_even_d;
  logic [7:0]                     shift_q, shift_d;
  logic [2:0]                     bit_cnt_q, bit_cnt_d;
  logic                           stop_cnt_q, stop_cnt_d;
  logic                           perr_acc_q, perr_acc_d;
  logic                           ferr_acc_q, ferr_acc_d;
  logic [7:0]                     data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           parity_error_q, parity_error_d;
  logic                           framing_error_q, framing_error_d;

  logic                           rx;
  logic                           timer_zero;
  logic                           ferr_now;
  logic [CLOCK_DIVIDER_WIDTH-1:0] div_clamped;

  assign rx          = sync_q[1];
  assign timer_zero  = (timer_q == '0);
  assign ferr_now    = ferr_acc_q | ~rx;
  assign div_clamped = (clock_divider_i < DIV_MIN) ? DIV_MIN : clock_divider_i;

  always_comb begin
    sync_d          = {sync_q[0], serial_i};
    rx_prev_d       = rx;
    state_d         = state_q;
    timer_d         = timer_q;
    div_d           = div_q;
    two_stop_d      = two_stop_q;
    par_en_d        = par_en_q;
    par_even_d      = par_even_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    stop_cnt_d      = stop_cnt_q;
    perr_acc_d      = perr_acc_q;
    ferr_acc_d      = ferr_acc_q;
    data_d          = data_q;
    valid_d         = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;

    case (state_q)
      ST_WAIT_IDLE: begin
        if (rx) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rx_prev_q && !rx) begin
          state_d    = ST_START;
          div_d      = div_clamped;
          two_stop_d = two_stop_bits_i;
          par_en_d   = parity_bit_i;
          par_even_d = parity_even_i;
          // half-period first load puts every later sample at mid-bit
          timer_d    = (div_clamped >> 1) - DIV_ONE;
        end
      end
      ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
        if (!timer_zero) begin
          timer_d = timer_q - DIV_ONE;
        end else begin
          timer_d = div_q - DIV_ONE;
          case (state_q)
            ST_START: begin
              if (!rx) begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
              end else begin
                state_d = ST_IDLE;
              end
            end
            ST_DATA: begin
              shift_d   = {rx, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_d    = par_en_q ? ST_PARITY : ST_STOP;
                stop_cnt_d = 1'b0;
                perr_acc_d = 1'b0;
                ferr_acc_d = 1'b0;
              end
            end
            ST_PARITY: begin
              perr_acc_d = ((^shift_q) ^ rx) != ~par_even_q;
              state_d    = ST_STOP;
            end
            default: begin
              if (!two_stop_q || stop_cnt_q) begin
                data_d          = shift_q;
                valid_d         = 1'b1;
                parity_error_d  = perr_acc_q;
                framing_error_d = ferr_now;
                state_d         = rx ? ST_IDLE : ST_WAIT_IDLE;
              end else begin
                stop_cnt_d = 1'b1;
                ferr_acc_d = ferr_now;
              end
            end
          endcase
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q          <= '1;
      rx_prev_q       <= 1'b1;
      state_q         <= ST_WAIT_IDLE;
      timer_q         <= '0;
      div_q           <= DIV_MIN;
      two_stop_q      <= 1'b0;
      par_en_q        <= 1'b0;
      par_even_q      <= 1'b0;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      stop_cnt_q      <= 1'b0;
      perr_acc_q      <= 1'b0;
      ferr_acc_q      <= 1'b0;
      data_q          <= '0;
      valid_q         <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      rx_prev_q       <= rx_prev_d;
      state_q         <= state_d;
      timer_q         <= timer_d;
      div_q           <= div_d;
      two_stop_q      <= two_stop_d;
      par_en_q        <= par_en_d;
      par_even_q      <= par_even_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      stop_cnt_q      <= stop_cnt_d;
      perr_acc_q      <= perr_acc_d;
      ferr_acc_q      <= ferr_acc_d;
      data_q          <= data_d;
      valid_q         <= valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign data_o          = data_q;
  assign valid_o         = valid_q;
  assign parity_error_o  = parity_error_q;
  assign framing_error_o = framing_error_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a bench-side serial driver sends frames, a negedge monitor
// records every valid strobe, and results are compared against hand-computed values.
module tb_uart_rx;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic        serial_i;
  logic [15:0] clock_divider_i;
  logic        two_stop_bits_i;
  logic        parity_bit_i;
  logic        parity_even_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        parity_error_o;
  logic        framing_error_o;
  logic        busy_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;

  logic [7:0]  got_data[$];
  logic        got_perr[$];
  logic        got_ferr[$];
  int unsigned got_cyc[$];
  logic [7:0]  exp_data[$];

  uart_rx #(.CLOCK_DIVIDER_WIDTH(16)) dut (
    .clock_i         (clock_i),
    .reset_n_i       (reset_n_i),
    .serial_i        (serial_i),
    .clock_divider_i (clock_divider_i),
    .two_stop_bits_i (two_stop_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .parity_error_o  (parity_error_o),
    .framing_error_o (framing_error_o),
    .busy_o          (busy_o)
  );

  always #5 clock_i = ~clock_i;

  always @(posedge clock_i) cyc <= cyc + 1;

  always @(negedge clock_i) begin
    if (valid_o) begin
      got_data.push_back(data_o);
      got_perr.push_back(parity_error_o);
      got_ferr.push_back(framing_error_o);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) begin
      @(posedge clock_i);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int unsigned d);
    serial_i = v;
    wait_cycles(d);
  endtask

  task automatic send_frame(input logic [7:0] b, input int unsigned d, input logic par_en,
                            input logic pbit, input logic two_stop, input logic stop_val);
    drive_bit(1'b0, d);
    for (int i = 0; i < 8; i++) drive_bit(b[i], d);
    if (par_en) drive_bit(pbit, d);
    drive_bit(stop_val, d);
    if (two_stop) drive_bit(stop_val, d);
  endtask

  task automatic clear_q();
    got_data.delete();
    got_perr.delete();
    got_ferr.delete();
    got_cyc.delete();
  endtask

  task automatic set_cfg(input logic [15:0] d, input logic par_en, input logic even, input logic two_stop);
    clock_divider_i = d;
    parity_bit_i    = par_en;
    parity_even_i   = even;
    two_stop_bits_i = two_stop;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, 32'(data_o), 32'h00);
    check({tag, "_valid"}, 32'(valid_o), 32'h0);
    check({tag, "_perr"}, 32'(parity_error_o), 32'h0);
    check({tag, "_ferr"}, 32'(framing_error_o), 32'h0);
    check({tag, "_busy"}, 32'(busy_o), 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t0;
    logic [7:0]  b;
    logic        pe, ev, ts, pbit;

    reset_n_i = 1'b0;
    serial_i  = 1'b1;
    set_cfg(16'd16, 1'b0, 1'b0, 1'b0);
    wait_cycles(5);
    check_reset_values("por");
    reset_n_i = 1'b1;
    wait_cycles(5);
    check("idle_busy", 32'(busy_o), 32'h0);

    // 8N1, D=16: 0xA5 then 0x3C back to back
    clear_q();
    t0 = cyc;
    send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_cycles(10);
    check("b2b_count", 32'(got_data.size()), 32'd2);
    if (got_data.size() >= 2) begin
      check("b2b_data0", 32'(got_data[0]), 32'hA5);
      check("b2b_data1", 32'(got_data[1]), 32'h3C);
      check("b2b_flags0", 32'({got_perr[0], got_ferr[0]}), 32'h0);
      check("b2b_flags1", 32'({got_perr[1], got_ferr[1]}), 32'h0);
      check("b2b_valid_cycle", got_cyc[0], t0 + 2 + 8 + 9 * 16 + 1);
    end
    check("b2b_busy_after", 32'(busy_o), 32'h0);

    // 8E2, D=10: 0x07 with parity bit 1, even then odd
    clear_q();
    set_cfg(16'd10, 1'b1, 1'b1, 1'b1);
    send_frame(8'h07, 10, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_cycles(10);
    set_cfg(16'd10, 1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 10, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_cycles(10);
    check("par_count", 32'(got_data.size()), 32'd2);
    if (got_data.size() >= 2) begin
      check("par_even_data", 32'(got_data[0]), 32'h07);
      check("par_even_perr", 32'(got_perr[0]), 32'h0);
      check("par_odd_data", 32'(got_data[1]), 32'h07);
      check("par_odd_perr", 32'(got_perr[1]), 32'h1);
      check("par_odd_ferr", 32'(got_ferr[1]), 32'h0);
    end

    // Framing error followed by a 40-bit break, then a clean frame
    clear_q();
    set_cfg(16'd16, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cycles(40 * 16);
    check("brk_count_low", 32'(got_data.size()), 32'd1);
    check("brk_busy_low", 32'(busy_o), 32'h1);
    serial_i = 1'b1;
    wait_cycles(32);
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_cycles(10);
    check("brk_count", 32'(got_data.size()), 32'd2);
    if (got_data.size() >= 2) begin
      check("brk_data0", 32'(got_data[0]), 32'h55);
      check("brk_ferr0", 32'(got_ferr[0]), 32'h1);
      check("brk_perr0", 32'(got_perr[0]), 32'h0);
      check("brk_data1", 32'(got_data[1]), 32'h81);
      check("brk_flags1", 32'({got_perr[1], got_ferr[1]}), 32'h0);
    end

    // Glitch: 5 low cycles is shorter than the mid-start sample point
    clear_q();
    serial_i = 1'b0;
    wait_cycles(5);
    serial_i = 1'b1;
    wait_cycles(10);
    check("glitch_busy", 32'(busy_o), 32'h0);
    wait_cycles(20);
    check("glitch_count", 32'(got_data.size()), 32'd0);

    // Reset during data bit 4 of 0xFF, released while the line is low
    clear_q();
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    serial_i = 1'b1;
    wait_cycles(8);
    reset_n_i = 1'b0;
    serial_i  = 1'b0;
    wait_cycles(3);
    check_reset_values("mid");
    reset_n_i = 1'b1;
    wait_cycles(3);
    serial_i = 1'b1;
    wait_cycles(40);
    check("mid_no_spurious", 32'(got_data.size()), 32'd0);
    send_frame(8'h12, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_cycles(10);
    check("mid_count", 32'(got_data.size()), 32'd1);
    if (got_data.size() >= 1)
      check("mid_data", 32'({got_perr[0], got_ferr[0], got_data[0]}), 32'h012);

    // Loopback-style: D=3 clamped to 4, random bytes and frame formats, zero gap
    clear_q();
    exp_data.delete();
    for (int n = 0; n < 256; n++) begin
      b    = 8'($urandom);
      pe   = 1'($urandom_range(0, 1));
      ev   = 1'($urandom_range(0, 1));
      ts   = 1'($urandom_range(0, 1));
      pbit = ev ? (^b) : ~(^b);
      set_cfg(16'd3, pe, ev, ts);
      exp_data.push_back(b);
      send_frame(b, 4, pe, pbit, ts, 1'b1);
    end
    wait_cycles(20);
    check("loop_count", 32'(got_data.size()), 32'd256);
    for (int n = 0; n < 256; n++) begin
      if (n < got_data.size())
        check("loop_byte", 32'({got_perr[n], got_ferr[n], got_data[n]}), 32'({2'b00, exp_data[n]}));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
